// File: rtl/core_pkg.sv
// Shared types and constants for the PC stage: FSM states, target-select codes,
// alignment helpers.
package core_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FAULT
   } pc_state_e;

   typedef enum logic [1:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_JAL,
      SEL_JALR
   } pc_sel_e;

   localparam logic [31:0] INSN_ALIGN_MASK = 32'h3;
   localparam logic [31:0] PC_STEP         = 32'd4;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr & INSN_ALIGN_MASK) != 32'h0;
   endfunction

   function automatic logic [31:0] force_align(input logic [31:0] addr);
      return addr & ~INSN_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Control-flow bus between the decode/compare stage and the PC stage.
// The perf counter outputs exist only when PC_PERF_CNT_EN is defined.
interface pc_next_unit_if;

   logic        advance;
   logic        is_branch;
   logic        branch_taken;
   logic        is_jal;
   logic        is_jalr;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        fault_clr;

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_en;
   logic        misalign_fault;
   logic [31:0] fault_pc;
   logic [31:0] fault_target;
`ifdef PC_PERF_CNT_EN
   logic [31:0] retired_cnt;
   logic [31:0] taken_cnt;
`endif

   modport master (
      output advance, is_branch, branch_taken, is_jal, is_jalr, imm, rs1_data, fault_clr,
      input  pc, pc_plus4, fetch_en, misalign_fault, fault_pc, fault_target
`ifdef PC_PERF_CNT_EN
      , input retired_cnt, taken_cnt
`endif
   );

   modport slave (
      input  advance, is_branch, branch_taken, is_jal, is_jalr, imm, rs1_data, fault_clr,
      output pc, pc_plus4, fetch_en, misalign_fault, fault_pc, fault_target
`ifdef PC_PERF_CNT_EN
      , output retired_cnt, taken_cnt
`endif
   );

endinterface

// File: rtl/pc_next_unit_target_sel.sv
// Combinational next-PC mux and misaligned-target detection.
// Priority: JALR > JAL > taken branch > sequential.
module pc_target_sel
   import core_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        is_branch,
   input  logic        branch_taken,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   output logic [31:0] pc_plus4,
   output logic [31:0] target,
   output pc_sel_e     sel,
   output logic        misaligned
);

   logic [31:0] pc_rel;
   logic [31:0] jalr_sum;

   assign pc_plus4 = pc + PC_STEP;
   assign pc_rel   = pc + imm;
   assign jalr_sum = rs1_data + imm;

   always_comb begin
      sel    = SEL_SEQ;
      target = pc_plus4;
      if (is_jalr) begin
         sel    = SEL_JALR;
         target = jalr_sum & ~32'h1;
      end else if (is_jal) begin
         sel    = SEL_JAL;
         target = pc_rel;
      end else if (is_branch && branch_taken) begin
         sel    = SEL_BR;
         target = pc_rel;
      end
   end

   // pc is always word-aligned, so the sequential target can never fault
   assign misaligned = (sel != SEL_SEQ) && is_misaligned(target);

endmodule

// File: rtl/pc_next_unit.sv
// PC register, boot sequencer and misalign-fault FSM.
// Optional macro PC_PERF_CNT_EN adds retired/taken counters on the bus.
//
// state | meaning
// BOOT  | post-reset hold, counting up to BOOT_DELAY, no fetch
// RUN   | fetching; pc advances to the selected target on advance
// FAULT | misaligned target seen; pc parked at TRAP_VECTOR until fault_clr
module pc_next_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned BOOT_DELAY   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   pc_next_unit_if.slave bus
);

   localparam logic [31:0] RESET_PC   = force_align(RESET_VECTOR);
   localparam logic [31:0] TRAP_PC    = force_align(TRAP_VECTOR);
   localparam logic [7:0]  BOOT_LIMIT = 8'(BOOT_DELAY);

   pc_state_e   state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic [31:0] fault_tgt_q, fault_tgt_d;

   logic [31:0] target;
   logic        misaligned;
`ifdef PC_PERF_CNT_EN
   pc_sel_e     sel;
   logic [31:0] retired_q, retired_d;
   logic [31:0] taken_q, taken_d;
`endif

   pc_target_sel u_target_sel (
      .pc           (pc_q),
      .is_branch    (bus.is_branch),
      .branch_taken (bus.branch_taken),
      .is_jal       (bus.is_jal),
      .is_jalr      (bus.is_jalr),
      .imm          (bus.imm),
      .rs1_data     (bus.rs1_data),
      .pc_plus4     (bus.pc_plus4),
      .target       (target),
`ifdef PC_PERF_CNT_EN
      .sel          (sel),
`else
      .sel          (),
`endif
      .misaligned   (misaligned)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_d        = pc_q;
      fault_pc_d  = fault_pc_q;
      fault_tgt_d = fault_tgt_q;
`ifdef PC_PERF_CNT_EN
      retired_d   = retired_q;
      taken_d     = taken_q;
`endif
      case (state_q)
         BOOT: begin
            if (cnt_q == BOOT_LIMIT) state_d = RUN;
            else                     cnt_d   = cnt_q + 8'd1;
         end
         RUN: begin
            if (bus.advance) begin
               if (misaligned) begin
                  fault_pc_d  = pc_q;
                  fault_tgt_d = target;
                  pc_d        = TRAP_PC;
                  state_d     = FAULT;
               end else begin
                  pc_d = target;
`ifdef PC_PERF_CNT_EN
                  retired_d = retired_q + 32'd1;
                  if (sel != SEL_SEQ) taken_d = taken_q + 32'd1;
`endif
               end
            end
         end
         FAULT: begin
            // pc already holds TRAP_PC; clearing resumes fetch right there
            if (bus.fault_clr) state_d = RUN;
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         cnt_q       <= 8'd0;
         pc_q        <= RESET_PC;
         fault_pc_q  <= 32'h0;
         fault_tgt_q <= 32'h0;
`ifdef PC_PERF_CNT_EN
         retired_q   <= 32'h0;
         taken_q     <= 32'h0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pc_q        <= pc_d;
         fault_pc_q  <= fault_pc_d;
         fault_tgt_q <= fault_tgt_d;
`ifdef PC_PERF_CNT_EN
         retired_q   <= retired_d;
         taken_q     <= taken_d;
`endif
      end
   end

   assign bus.pc             = pc_q;
   assign bus.fetch_en       = (state_q == RUN);
   assign bus.misalign_fault = (state_q == FAULT);
   assign bus.fault_pc       = fault_pc_q;
   assign bus.fault_target   = fault_tgt_q;
`ifdef PC_PERF_CNT_EN
   assign bus.retired_cnt    = retired_q;
   assign bus.taken_cnt      = taken_q;
`endif

endmodule
